// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add WIDTH x WIDTH multiplier with a start/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands and product.
module mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t              state_q, state_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d, acc_q, acc_d, z_q, z_d, sum, res;
  logic [WIDTH-1:0]    mplier_q, mplier_d, xm, ym;
  logic [CW-1:0]       cnt_q, cnt_d;
`ifdef MULT_SIGNED_EN
  logic sgn_q, sgn_d;
  // magnitude of the most negative value still fits as an unsigned WIDTH-bit number
  assign xm  = x[WIDTH-1] ? -x : x;
  assign ym  = y[WIDTH-1] ? -y : y;
  assign res = sgn_q ? -sum : sum;
`else
  assign xm  = x;
  assign ym  = y;
  assign res = sum;
`endif
  assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
`ifdef MULT_SIGNED_EN
    sgn_d    = sgn_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        mcand_d  = {{WIDTH{1'b0}}, xm};
        mplier_d = ym;
        acc_d    = '0;
        cnt_d    = '0;
`ifdef MULT_SIGNED_EN
        sgn_d    = x[WIDTH-1] ^ y[WIDTH-1];
`endif
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // load z on the last bit so it is already valid while done is high
        if (cnt_q == LAST) begin
          state_d = DONE;
          z_d     = res;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      z_q      <= '0;
`ifdef MULT_SIGNED_EN
      sgn_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
`ifdef MULT_SIGNED_EN
      sgn_q    <= sgn_d;
`endif
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign z    = z_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: scoreboard bench for mult_seq at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random).
module tb_mult_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic start4 = 1'b0, start8 = 1'b0;
  logic [3:0] x4 = '0, y4 = '0;
  logic [7:0] x8 = '0, y8 = '0;
  logic busy4, done4, busy8, done8;
  logic [7:0] z4;
  logic [15:0] z8;
  logic [7:0] q4[$];
  logic [15:0] q8[$];
  int checks = 0, failures = 0, dones4 = 0, dones8 = 0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4),
                            .busy(busy4), .done(done4), .z(z4));
  mult_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
                            .busy(busy8), .done(done8), .z(z8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b);
`ifdef MULT_SIGNED_EN
    int sa = $signed(a), sb = $signed(b);
`else
    int sa = a, sb = b;
`endif
    return 8'(sa * sb);
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SIGNED_EN
    int sa = $signed(a), sb = $signed(b);
`else
    int sa = a, sb = b;
`endif
    return 16'(sa * sb);
  endfunction

  always @(negedge clk) begin
    if (!rst && done4) begin
      dones4++;
      if (q4.size() == 0) check("z4_spurious_done", 1, 0);
      else check("z4", z4, q4.pop_front());
    end
    if (!rst && done8) begin
      dones8++;
      if (q8.size() == 0) check("z8_spurious_done", 1, 0);
      else check("z8", z8, q8.pop_front());
    end
  end

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int n;
    @(negedge clk);
    x4 = a; y4 = b; start4 = 1'b1;
    q4.push_back(model4(a, b));
    @(posedge clk); #1;
    start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom);
    n = 1;
    check("busy4_run", busy4, 1);
    while (!done4 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("lat4", n, 5);
    @(posedge clk); #1;
    check("idle4_after", busy4, 0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    x8 = a; y8 = b; start8 = 1'b1;
    q8.push_back(model8(a, b));
    @(posedge clk); #1;
    start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
    n = 1;
    while (!done8 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (n != 9) check("lat8", n, 9);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    #1;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_z", z4, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // T1, T2
    run4(4'b1011, 4'b0101);
    run4(4'b1111, 4'b1111);
    run4(4'b1111, 4'b0000);
    run4(4'b0000, 4'b1001);
    // T3: start held high, operands changing every cycle
    d0 = dones4;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      x4 = (k == 0) ? 4'b1010 : (k == 6) ? 4'b0111 : 4'($urandom);
      y4 = (k == 0) ? 4'b1101 : (k == 6) ? 4'b0011 : 4'($urandom);
      start4 = 1'b1;
      if (k % 6 == 0) q4.push_back(model4(x4, y4));
    end
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_dones", dones4 - d0, 2);
    // T4: asynchronous reset in RUN cycle 2
    @(negedge clk);
    x4 = 4'b0110; y4 = 4'b1001; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t4_busy", busy4, 0);
    check("t4_done", done4, 0);
    check("t4_z", z4, 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = dones4;
    repeat (8) @(negedge clk);
    check("t4_no_done", dones4 - d0, 0);
    run4(4'b0110, 4'b1001);
    // T5 vectors (expectations follow the build's signedness)
    run4(4'b1111, 4'b1111);
    run4(4'b1000, 4'b1000);
    run4(4'b0111, 4'b1000);
    // exhaustive sweep at WIDTH=4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4(4'(a), 4'(b));
    // T6: WIDTH=8 corners plus random pairs
    run8(8'hFF, 8'hFF);
    run8(8'h80, 8'h80);
    run8(8'h7F, 8'h80);
    run8(8'h00, 8'hA5);
    for (int i = 0; i < 1500; i++) run8(8'($urandom), 8'($urandom));
    repeat (3) @(negedge clk);
    check("q4_drained", q4.size(), 0);
    check("q8_drained", q8.size(), 0);
    check("dones8", dones8, 1504);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
